// File: rtl/ff_array_rmw_ctrl.sv
// Read-modify-write controller for a two-port flop metadata array.
// Port 1 reads the old entry, the merged value goes back on port 0 a cycle
// later, and a one-deep forward register covers the array's write latency.
// A clear sweep zeroes every set, one write per cycle.
module ff_array_rmw_ctrl #(
   parameter int S_INDEX = 4,
   parameter int WIDTH   = 1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               req_valid,
   output logic               req_ready,
   input  logic [S_INDEX-1:0] req_addr,
   input  logic [WIDTH-1:0]   req_mask,
   input  logic [WIDTH-1:0]   req_data,
   output logic               rsp_valid,
   output logic [WIDTH-1:0]   rsp_old,
   output logic [WIDTH-1:0]   rsp_new,
   input  logic               clear_start,
   output logic               clear_busy,
   output logic               clear_done,
   output logic               arr_csb0,
   output logic               arr_web0,
   output logic [S_INDEX-1:0] arr_addr0,
   output logic [WIDTH-1:0]   arr_din0,
   output logic               arr_csb1,
   output logic [S_INDEX-1:0] arr_addr1,
   input  logic [WIDTH-1:0]   arr_dout1
);

   localparam int NUM_SETS = 2**S_INDEX;
   localparam logic [S_INDEX-1:0] LAST_SET = S_INDEX'(NUM_SETS - 1);

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      CLEAR
   } state_e;

   state_e             state_q, state_d;
   logic               clear_pend_q, clear_pend_d;
   logic [S_INDEX-1:0] clr_idx_q, clr_idx_d;
   logic               clear_done_q, clear_done_d;

   logic               s2_valid_q;
   logic [S_INDEX-1:0] s2_addr_q;
   logic [WIDTH-1:0]   s2_mask_q;
   logic [WIDTH-1:0]   s2_data_q;

   logic               fwd_valid_q;
   logic [S_INDEX-1:0] fwd_addr_q;
   logic [WIDTH-1:0]   fwd_data_q;

   logic               accept;
   logic               fwd_hit;
   logic [WIDTH-1:0]   old_val;
   logic [WIDTH-1:0]   new_val;
   logic               wr_en;
   logic [S_INDEX-1:0] wr_addr;
   logic [WIDTH-1:0]   wr_data;

   // Requests are refused once a clear has been asked for, so the S2 stage
   // drains before the sweep begins.
   assign req_ready = (state_q == RUN) && !clear_pend_q;
   assign accept    = req_valid && req_ready;

   // Merge stage: old value comes from the forward register when the write
   // issued last cycle targets the same set, since the array cannot show it yet.
   always_comb begin
      fwd_hit = s2_valid_q && fwd_valid_q && (fwd_addr_q == s2_addr_q);
      old_val = fwd_hit ? fwd_data_q : arr_dout1;
      new_val = (old_val & ~s2_mask_q) | (s2_data_q & s2_mask_q);
   end

   // Port-0 write source: the S2 merge result, or a zero during the sweep;
   // S2 is always empty while clearing, so the two never collide.
   always_comb begin
      wr_en   = s2_valid_q || (state_q == CLEAR);
      wr_addr = '0;
      wr_data = '0;
      if (s2_valid_q) begin
         wr_addr = s2_addr_q;
         wr_data = new_val;
      end else if (state_q == CLEAR) begin
         wr_addr = clr_idx_q;
      end
   end

   // Array pins and response outputs. Port 0 stays selected, and web0 is
   // held high on idle cycles so a latched enable never replays a write.
   always_comb begin
      arr_csb0   = 1'b0;
      arr_web0   = !wr_en;
      arr_addr0  = wr_addr;
      arr_din0   = wr_data;
      arr_csb1   = !accept;
      arr_addr1  = accept ? req_addr : '0;
      rsp_valid  = s2_valid_q;
      rsp_old    = s2_valid_q ? old_val : '0;
      rsp_new    = s2_valid_q ? new_val : '0;
      clear_busy = (state_q == CLEAR);
      clear_done = clear_done_q;
   end

   // Control FSM: clear requests are remembered until the pipeline is empty
   // and no request is entering it; a clear_start during the sweep is dropped.
   always_comb begin
      state_d      = state_q;
      clear_pend_d = clear_pend_q;
      clr_idx_d    = clr_idx_q;
      clear_done_d = 1'b0;
      case (state_q)
         IDLE: begin
            state_d = RUN;
            if (clear_start) begin
               clear_pend_d = 1'b1;
            end
         end
         RUN: begin
            if ((clear_start || clear_pend_q) && !s2_valid_q && !accept) begin
               state_d      = CLEAR;
               clear_pend_d = 1'b0;
               clr_idx_d    = '0;
            end else if (clear_start) begin
               clear_pend_d = 1'b1;
            end
         end
         CLEAR: begin
            clr_idx_d = clr_idx_q + 1'b1;
            if (clr_idx_q == LAST_SET) begin
               state_d      = RUN;
               clear_done_d = 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State, sweep counter and done pulse registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         clear_pend_q <= 1'b0;
         clr_idx_q    <= '0;
         clear_done_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         clear_pend_q <= clear_pend_d;
         clr_idx_q    <= clr_idx_d;
         clear_done_q <= clear_done_d;
      end
   end

   // S2 pipeline register, loaded by each accepted request.
   always_ff @(posedge clk) begin
      if (rst) begin
         s2_valid_q <= 1'b0;
         s2_addr_q  <= '0;
         s2_mask_q  <= '0;
         s2_data_q  <= '0;
      end else begin
         s2_valid_q <= accept;
         if (accept) begin
            s2_addr_q <= req_addr;
            s2_mask_q <= req_mask;
            s2_data_q <= req_data;
         end
      end
   end

   // Forward register tracks the most recent write; holding it across idle
   // cycles is safe because no later write could have superseded it.
   always_ff @(posedge clk) begin
      if (rst) begin
         fwd_valid_q <= 1'b0;
         fwd_addr_q  <= '0;
         fwd_data_q  <= '0;
      end else if (wr_en) begin
         fwd_valid_q <= 1'b1;
         fwd_addr_q  <= wr_addr;
         fwd_data_q  <= wr_data;
      end
   end

endmodule

// File: tb/tb_ff_array_rmw_ctrl.sv
// Directed bench for ff_array_rmw_ctrl with a behavioural two-port array,
// a reference copy of the array contents and a response scoreboard.
module tb_ff_array_rmw_ctrl;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       req_valid = 1'b0;
   logic       req_ready;
   logic [3:0] req_addr = '0;
   logic [7:0] req_mask = '0;
   logic [7:0] req_data = '0;
   logic       rsp_valid;
   logic [7:0] rsp_old;
   logic [7:0] rsp_new;
   logic       clear_start = 1'b0;
   logic       clear_busy;
   logic       clear_done;
   logic       arr_csb0;
   logic       arr_web0;
   logic [3:0] arr_addr0;
   logic [7:0] arr_din0;
   logic       arr_csb1;
   logic [3:0] arr_addr1;
   logic [7:0] arr_dout1 = '0;

   int tests = 0;
   int fails = 0;

   logic [15:0] expQ[$];
   logic [7:0]  refMem[16];
   logic [15:0] monEntry;

   // Behavioural array: a write is latched at the edge ending its cycle and
   // lands at the next edge; a read in that landing cycle already sees it.
   logic [7:0] mem[16] = '{default: 8'h00};
   logic       pwValid = 1'b0;
   logic [3:0] pwAddr = '0;
   logic [7:0] pwData = '0;

   ff_array_rmw_ctrl #(.S_INDEX(4), .WIDTH(8)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_addr(req_addr), .req_mask(req_mask), .req_data(req_data),
      .rsp_valid(rsp_valid), .rsp_old(rsp_old), .rsp_new(rsp_new),
      .clear_start(clear_start), .clear_busy(clear_busy), .clear_done(clear_done),
      .arr_csb0(arr_csb0), .arr_web0(arr_web0), .arr_addr0(arr_addr0), .arr_din0(arr_din0),
      .arr_csb1(arr_csb1), .arr_addr1(arr_addr1), .arr_dout1(arr_dout1)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      pwValid <= (arr_csb0 === 1'b0) && (arr_web0 === 1'b0);
      pwAddr  <= arr_addr0;
      pwData  <= arr_din0;
      if (pwValid) mem[pwAddr] <= pwData;
      if (arr_csb1 === 1'b0) arr_dout1 <= (pwValid && pwAddr == arr_addr1) ? pwData : mem[arr_addr1];
   end

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Responses are compared against the scoreboard in issue order.
   always @(negedge clk) begin
      if (rst === 1'b0 && rsp_valid === 1'b1) begin
         if (expQ.size() == 0) begin
            checkOutput("rsp_unexpected", 32'd1, 32'd0);
         end else begin
            monEntry = expQ.pop_front();
            checkOutput("rsp_old", {24'd0, rsp_old}, {24'd0, monEntry[15:8]});
            checkOutput("rsp_new", {24'd0, rsp_new}, {24'd0, monEntry[7:0]});
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic waitReady();
      int n = 0;
      while (req_ready !== 1'b1 && n < 60) begin
         tick();
         n++;
      end
      checkOutput("ready_timeout", {31'd0, req_ready}, 32'd1);
   endtask

   // Drive one request for one cycle and record its expected response.
   task automatic applyStimulus(input logic [3:0] addr, input logic [7:0] mask, input logic [7:0] data);
      logic [7:0] o;
      logic [7:0] n;
      if (req_ready !== 1'b1) waitReady();
      req_valid = 1'b1;
      req_addr  = addr;
      req_mask  = mask;
      req_data  = data;
      o = refMem[addr];
      n = (o & ~mask) | (data & mask);
      expQ.push_back({o, n});
      refMem[addr] = n;
      tick();
   endtask

   task automatic drain();
      req_valid = 1'b0;
      repeat (4) tick();
      checkOutput("queue_drained", expQ.size(), 32'd0);
   endtask

   task automatic preloadOnes();
      for (int s = 0; s < 16; s++) applyStimulus(s[3:0], 8'hFF, 8'hFF);
      drain();
   endtask

   initial begin
      int busyCnt;
      int doneCnt;
      int rspCyc;
      int busyCyc;
      bit sent;
      for (int i = 0; i < 16; i++) refMem[i] = 8'h00;

      repeat (2) tick();
      checkOutput("rst_req_ready", {31'd0, req_ready}, 32'd0);
      checkOutput("rst_rsp", {22'd0, rsp_valid, rsp_old, rsp_new}, 32'd0);
      checkOutput("rst_clear", {30'd0, clear_busy, clear_done}, 32'd0);
      checkOutput("rst_port0", {18'd0, arr_csb0, arr_web0, arr_addr0, arr_din0}, 32'h1000);
      checkOutput("rst_port1", {27'd0, arr_csb1, arr_addr1}, 32'h10);
      rst = 1'b0;
      waitReady();

      // Single RMW on set 3.
      applyStimulus(4'd3, 8'h0F, 8'hA5);
      drain();
      checkOutput("set3_array", {24'd0, mem[3]}, 32'h05);

      // Back-to-back requests to set 7 chain through the forward path.
      applyStimulus(4'd7, 8'h01, 8'h01);
      applyStimulus(4'd7, 8'h02, 8'h02);
      applyStimulus(4'd7, 8'h80, 8'h80);
      drain();
      checkOutput("set7_array", {24'd0, mem[7]}, 32'h83);

      // Interleaved sets.
      applyStimulus(4'd1, 8'hFF, 8'h11);
      applyStimulus(4'd2, 8'hFF, 8'h22);
      applyStimulus(4'd1, 8'hFF, 8'h33);
      drain();
      checkOutput("set2_array", {24'd0, mem[2]}, 32'h22);
      checkOutput("set1_array", {24'd0, mem[1]}, 32'h33);

      // Full clear over an all-ones array, then a set-15 read in the done cycle.
      preloadOnes();
      clear_start = 1'b1;
      for (int i = 0; i < 16; i++) refMem[i] = 8'h00;
      tick();
      clear_start = 1'b0;
      busyCnt = 0;
      doneCnt = 0;
      sent = 1'b0;
      for (int c = 0; c < 40; c++) begin
         if (clear_busy === 1'b1) begin
            checkOutput("clear_write", {19'd0, arr_web0, arr_addr0, arr_din0}, {19'd0, 1'b0, busyCnt[3:0], 8'h00});
            busyCnt++;
         end
         if (clear_done === 1'b1) begin
            doneCnt++;
            if (!sent) begin
               sent = 1'b1;
               applyStimulus(4'd15, 8'h00, 8'h00);
               req_valid = 1'b0;
               continue;
            end
         end
         tick();
      end
      checkOutput("clear_busy_cycles", busyCnt, 32'd16);
      checkOutput("clear_done_pulses", doneCnt, 32'd1);
      drain();
      checkOutput("clear_set9_array", {24'd0, mem[9]}, 32'h00);

      // Clear requested in the same cycle as an accepted request to set 4.
      applyStimulus(4'd1, 8'hFF, 8'h5A);
      drain();
      clear_start = 1'b1;
      applyStimulus(4'd4, 8'hFF, 8'h44);
      for (int i = 0; i < 16; i++) refMem[i] = 8'h00;
      clear_start = 1'b0;
      req_valid = 1'b0;
      rspCyc = -1;
      busyCyc = -1;
      for (int c = 0; c < 40; c++) begin
         if (rsp_valid === 1'b1 && rspCyc < 0) rspCyc = c;
         if (clear_busy === 1'b1 && busyCyc < 0) busyCyc = c;
         tick();
      end
      checkOutput("collision_order", {31'd0, (rspCyc >= 0) && (busyCyc > rspCyc)}, 32'd1);
      checkOutput("collision_set4", {24'd0, mem[4]}, 32'h00);
      checkOutput("collision_set1", {24'd0, mem[1]}, 32'h00);

      // Reset in the middle of a sweep.
      preloadOnes();
      clear_start = 1'b1;
      tick();
      clear_start = 1'b0;
      busyCnt = 0;
      while (!(clear_busy === 1'b1 && arr_addr0 == 4'd6) && busyCnt < 40) begin
         tick();
         busyCnt++;
      end
      checkOutput("sweep_reach_6", {31'd0, clear_busy}, 32'd1);
      rst = 1'b1;
      tick();
      checkOutput("midrst_ready", {31'd0, req_ready}, 32'd0);
      checkOutput("midrst_rsp", {22'd0, rsp_valid, rsp_old, rsp_new}, 32'd0);
      checkOutput("midrst_port0", {18'd0, arr_csb0, arr_web0, arr_addr0, arr_din0}, 32'h1000);
      checkOutput("midrst_port1", {27'd0, arr_csb1, arr_addr1}, 32'h10);
      doneCnt = 0;
      for (int c = 0; c < 3; c++) begin
         if (clear_done !== 1'b0 || clear_busy !== 1'b0) doneCnt++;
         tick();
      end
      checkOutput("midrst_no_done", doneCnt, 32'd0);
      rst = 1'b0;
      repeat (3) tick();
      for (int s = 0; s < 6; s++) checkOutput($sformatf("midrst_set%0d", s), {24'd0, mem[s]}, 32'h00);
      for (int s = 7; s < 16; s++) checkOutput($sformatf("midrst_set%0d", s), {24'd0, mem[s]}, 32'hFF);
      checkOutput("midrst_set6", {31'd0, (mem[6] == 8'h00) || (mem[6] == 8'hFF)}, 32'd1);
      checkOutput("final_queue", expQ.size(), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/ff_array_rmw_ctrl.md
Name: ff_array_rmw_ctrl

Overview:
- Initiator-side controller for the two-port flop metadata array: port 0 is a registered write; port 1 is a registered-address read.
- Accepts masked read-modify-write requests from the cache datapath, reads the old value on port 1, merges the update, and writes the result back on port 0.
- Sustains one request per cycle, with a one-deep write forward to cover array latency.
- Also provides a clear sweep that zeroes every set.

Parameters:
- S_INDEX, 4, set-index width; NUM_SETS = 2**S_INDEX.
- WIDTH, 1, bits per array entry.

Ports:
- clk  in  1  single clock for the block and the array.
- rst  in  1  synchronous reset, active-high.
- req_valid  in  1  RMW request valid.
- req_ready  out  1  controller can accept a request this cycle.
- req_addr  in  S_INDEX  target set.
- req_mask  in  WIDTH  bits to update.
- req_data  in  WIDTH  new values for masked bits.
- rsp_valid  out  1  single-cycle pulse; the response for the oldest accepted request.
- rsp_old  out  WIDTH  entry value before the update.
- rsp_new  out  WIDTH  entry value written back.
- clear_start  in  1  request a full-array clear.
- clear_busy  out  1  clear sweep in progress.
- clear_done  out  1  single-cycle pulse after the last clear write is issued.
- arr_csb0  out  1  array port-0 chip select, active-low.
- arr_web0  out  1  array port-0 write enable, active-low.
- arr_addr0  out  S_INDEX  array write address.
- arr_din0  out  WIDTH  array write data.
- arr_csb1  out  1  array port-1 chip select, active-low.
- arr_addr1  out  S_INDEX  array read address.
- arr_dout1  in  WIDTH  array read data; valid the cycle after arr_addr1 is presented with arr_csb1=0.

Behaviour:
- Array timing:
  - A read presented in cycle T returns on arr_dout1 in T+1.
  - A write presented in cycle T (csb0=0, web0=0) updates the array at the end of T+1 and is readable on arr_dout1 in T+2.
- Port-0 hygiene: arr_csb0 is held at 0 every cycle. arr_web0=1 in every cycle with no write, so the array's held write enable never re-fires a stale write.
- Reset values:
  - req_ready=0, rsp_valid=0, rsp_old/rsp_new=0.
  - clear_busy=0, clear_done=0.
  - arr_csb0=0, arr_web0=1, arr_csb1=1.
  - arr_addr0/arr_addr1/arr_din0=0.
  - FSM=IDLE, pipeline valid bits=0, forward register invalid.
- FSM states: IDLE, RUN, CLEAR.
  - IDLE→RUN: first cycle after reset deasserts.
  - RUN→CLEAR: clear_start=1 and the S2 stage is empty.
  - CLEAR→RUN: after the write to set NUM_SETS-1 is issued.
  - A clear_start arriving during CLEAR is ignored.
  - While clear_start is pending (requested but not yet entered), req_ready=0.
- req_ready = (state==RUN) and no pending clear. Handshake: req_valid and req_ready are sampled high in the same cycle.
- Stage S1 (accept cycle T):
  - arr_csb1=0, arr_addr1=req_addr.
  - Latch addr, mask and data into S2; S2 is valid in T+1.
- Stage S2 (cycle T+1):
  - old = fwd_hit ? fwd_data : arr_dout1.
  - new = (old & ~mask) | (data & mask).
  - Drive arr_web0=0, arr_addr0=addr, arr_din0=new.
  - rsp_valid=1, rsp_old=old, rsp_new=new, all in the same cycle.
- Forward register: records (addr, data) of the write issued in the previous cycle, from either an RMW or a clear write. fwd_hit = S2 valid, forward valid, and addr match.
  - Writes two or more cycles older are visible in the array and need no forward.
- Back-to-back requests to the same set chain correctly through the forward path at full rate.
- CLEAR sweep:
  - One write per cycle: sets 0..NUM_SETS-1 in order, data '0.
  - clear_busy=1 throughout; the index counter starts at 0 on entry.
  - clear_done pulses in the cycle after the final write; the state is RUN in that cycle.
  - A request accepted in that cycle that reads set NUM_SETS-1 uses the forward path.
- Simultaneous events:
  - rst dominates everything.
  - clear_start while S2 is valid: S2 completes its write first, then CLEAR is entered.
  - A request accepted in the same cycle as clear_start completes before CLEAR is entered.
- Reset mid-sweep or mid-RMW:
  - In-flight operations are abandoned with no response.
  - The array contents written so far remain; nothing is rolled back.

Test Plan:
- Use S_INDEX=4, WIDTH=8 unless stated.
- Single RMW: set 3 holds 0x00; req addr=3, mask=0x0F, data=0xA5 → rsp_old=0x00, rsp_new=0x05. Array read of set 3 two cycles after the write returns 0x05.
- Back-to-back same set: three consecutive requests to set 7 with (mask 0x01, data 0x01), (0x02, 0x02), (0x80, 0x80) → rsp_new = 0x01, 0x03, 0x83. Second and third responses use the forward path; no bubbles.
- Interleaved sets: requests to sets 1, 2, 1 on consecutive cycles with mask 0xFF and data 0x11, 0x22, 0x33 → the third rsp_old=0x11. Set 2 ends at 0x22, set 1 at 0x33.
- Clear:
  - Preload sets 0..15 with 0xFF, then pulse clear_start.
  - Expect 16 consecutive port-0 writes of 0x00 to sets 0..15, clear_busy high for 16 cycles, and clear_done exactly once.
  - A request to set 15 with mask 0x00 in the next cycle → rsp_old=0x00.
- Clear vs request collision: clear_start in the same cycle as an accepted request to set 4 (mask 0xFF, data 0x44) → the RMW response appears first, then the clear runs, and set 4 ends at 0x00.
- Reset mid-sweep: assert rst at sweep index 6 → all outputs take reset values next cycle, no clear_done pulse. Sets 0..5 hold 0x00 and sets 6..15 retain 0xFF; a set-6 write is permitted only if already issued.
